// File: rtl/cache_line_burst_adapter.sv
// Cache line burst adapter.
// Splits whole-line fills and writebacks into BEATS sequential bus-wide beats
// on a simple request/valid memory bus. A combined request performs the
// writeback first and then the fill, and signals completion once at the end.
// All state and all outputs are registered; reset is synchronous, active-low.

module cache_line_burst_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  re,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [LINE_WIDTH-1:0] line_in,
    output logic                  busy,
    output logic                  ready,
    output logic [LINE_WIDTH-1:0] line_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_valid
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int BEATS  = LINE_WIDTH / BUS_WIDTH;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFFS_W = $clog2(LINE_WIDTH / 8);
    localparam int STEP   = BUS_WIDTH / 8;

    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1'b1) << OFFS_W) - ADDR_WIDTH'(1'b1));
    localparam logic [BUS_WIDTH-1:0]  DATA_ZERO  = {BUS_WIDTH{1'b0}};
    localparam logic [LINE_WIDTH-1:0] LINE_ZERO  = {LINE_WIDTH{1'b0}};

    // Reject parameter sets the beat arithmetic cannot represent.
    if ((BUS_WIDTH % 8) != 0 || (LINE_WIDTH % BUS_WIDTH) != 0 ||
        BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || OFFS_W >= ADDR_WIDTH) begin : g_bad_params
        $error("cache_line_burst_adapter: unsupported LINE_WIDTH/BUS_WIDTH/ADDR_WIDTH combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Clear the byte offset within a line.
    function automatic logic [ADDR_WIDTH-1:0] align_line(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // Bus-wide slice of a line for a beat index; beat 0 is the LS slice.
    function automatic logic [BUS_WIDTH-1:0] beat_slice(input logic [LINE_WIDTH-1:0] line,
                                                        input logic [CNT_W-1:0]      idx);
        return line[BUS_WIDTH*int'(idx) +: BUS_WIDTH];
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    pend_r;       // fill still owed after a writeback
    logic [ADDR_WIDTH-1:0]   fill_base_r;  // aligned fill address for a combined request
    logic [LINE_WIDTH-1:0]   line_r;       // writeback data captured at request time
    logic                    busy_r;
    logic                    ready_r;
    logic                    mem_req_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [BUS_WIDTH-1:0]    mem_wdata_r;
    logic [LINE_WIDTH-1:0]   line_out_r;

    // ------------------------------------------------------------------
    // Combinational helpers for the sequencer
    // ------------------------------------------------------------------
    logic                    beat_done_s;
    logic                    last_beat_s;
    logic [CNT_W-1:0]        cnt_next_s;
    logic [ADDR_WIDTH-1:0]   next_addr_s;
    logic [BUS_WIDTH-1:0]    next_wdata_s;
    logic [ADDR_WIDTH-1:0]   fill_base_s;
    logic [ADDR_WIDTH-1:0]   wb_base_s;
    logic [BUS_WIDTH-1:0]    first_wdata_s;

    // Beat completion, explicit counter wrap and next-beat address/data.
    always_comb begin
        beat_done_s   = mem_req_r & mem_valid;
        last_beat_s   = (cnt_r == LAST_BEAT);
        if (last_beat_s) begin
            cnt_next_s = CNT_ZERO;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
        next_addr_s   = mem_addr_r + ADDR_STEP;
        next_wdata_s  = beat_slice(line_r, cnt_next_s);
        fill_base_s   = align_line(fill_addr);
        wb_base_s     = align_line(wb_addr);
        first_wdata_s = beat_slice(line_in, CNT_ZERO);
    end

    // Burst sequencer: request decode in IDLE, beat stepping in WRITE/READ,
    // one-cycle completion pulse in DONE. Every output is a register here.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            pend_r      <= 1'b0;
            fill_base_r <= ADDR_ZERO;
            line_r      <= LINE_ZERO;
            busy_r      <= 1'b0;
            ready_r     <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= ADDR_ZERO;
            mem_wdata_r <= DATA_ZERO;
            line_out_r  <= LINE_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                    if (re && we) begin
                        // Writeback first; the fill address is parked until then.
                        fill_base_r <= fill_base_s;
                        line_r      <= line_in;
                        pend_r      <= 1'b1;
                        mem_addr_r  <= wb_base_s;
                        mem_wdata_r <= first_wdata_s;
                        mem_we_r    <= 1'b1;
                        mem_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= WRITE;
                    end else if (we) begin
                        line_r      <= line_in;
                        pend_r      <= 1'b0;
                        mem_addr_r  <= wb_base_s;
                        mem_wdata_r <= first_wdata_s;
                        mem_we_r    <= 1'b1;
                        mem_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= WRITE;
                    end else if (re) begin
                        fill_base_r <= fill_base_s;
                        pend_r      <= 1'b0;
                        mem_addr_r  <= fill_base_s;
                        mem_we_r    <= 1'b0;
                        mem_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= READ;
                    end else begin
                        mem_req_r   <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end

                WRITE: begin
                    if (beat_done_s) begin
                        cnt_r <= cnt_next_s;
                        if (last_beat_s) begin
                            if (pend_r) begin
                                // Switch straight to the fill; mem_req stays high.
                                pend_r     <= 1'b0;
                                mem_we_r   <= 1'b0;
                                mem_addr_r <= fill_base_r;
                                state_r    <= READ;
                            end else begin
                                mem_req_r  <= 1'b0;
                                mem_we_r   <= 1'b0;
                                ready_r    <= 1'b1;
                                state_r    <= DONE;
                            end
                        end else begin
                            mem_addr_r  <= next_addr_s;
                            mem_wdata_r <= next_wdata_s;
                        end
                    end else begin
                        // Wait state: address and data held.
                        state_r <= WRITE;
                    end
                end

                READ: begin
                    if (beat_done_s) begin
                        line_out_r[BUS_WIDTH*int'(cnt_r) +: BUS_WIDTH] <= mem_rdata;
                        cnt_r <= cnt_next_s;
                        if (last_beat_s) begin
                            mem_req_r <= 1'b0;
                            ready_r   <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            mem_addr_r <= next_addr_s;
                        end
                    end else begin
                        state_r <= READ;
                    end
                end

                DONE: begin
                    ready_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    cnt_r     <= CNT_ZERO;
                    state_r   <= IDLE;
                end

                default: begin
                    // Unreachable encoding: return to a quiet, idle bus.
                    ready_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    pend_r    <= 1'b0;
                    cnt_r     <= CNT_ZERO;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign ready     = ready_r;
    assign line_out  = line_out_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
